// File: rtl/h_mux_merge_pkg.sv
// Shared definitions for the merge/demux fabric: source-select encoding and default word width.
package h_mux_merge_pkg;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_e;

   localparam int unsigned DEFAULT_WIDTH = 16;

endpackage

// File: rtl/h_mux_merge_arb.sv
// Two-requester round-robin arbiter; owns the 'last granted' bit.
module h_rr_arb2
   import h_mux_merge_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   sel_e last;

   // On a tie the channel that did not win last time gets the grant.
   always_comb begin
      gnt = '0;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == SEL_A) ? 2'b10 : 2'b01;
         default: gnt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= SEL_B;
      end else if (advance && (gnt != 2'b00)) begin
         last <= gnt[1] ? SEL_B : SEL_A;
      end
   end

endmodule

// File: rtl/h_mux_merge.sv
// Two-to-one round-robin stream merger with a registered, source-tagged output stage.
module h_mux_merge
   import h_mux_merge_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sel,
   output logic             out_valid,
   input  logic             out_ready
);

   logic       load;
   logic [1:0] gnt;
   logic       xfer;

   assign load    = !out_valid || out_ready;
   assign a_ready = load && gnt[0];
   assign b_ready = load && gnt[1];
   assign xfer    = a_ready || b_ready;

   h_rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({b_valid, a_valid}),
      .advance (load),
      .gnt     (gnt)
   );

   // Data/tag only move on a transfer; a drain with no grant just clears valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_sel   <= SEL_A;
         out_valid <= 1'b0;
      end else if (xfer) begin
         out_data  <= gnt[1] ? b_data : a_data;
         out_sel   <= gnt[1] ? SEL_B : SEL_A;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_h_mux_merge.sv
// Directed bench for h_mux_merge: reset, single channel, contention, backpressure, drain.
module tb_h_mux_merge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a_data, b_data, out_data;
   logic        a_valid, a_ready, b_valid, b_ready;
   logic        out_sel, out_valid, out_ready;

   int checks   = 0;
   int failures = 0;

   h_mux_merge #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_data    (a_data),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .b_data    (b_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [15:0] d, input logic s, input logic v);
      check({tag, ".data"},  out_data,  d);
      check({tag, ".sel"},   {15'd0, out_sel},   {15'd0, s});
      check({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
   endtask

   task automatic check_rdy(input string tag, input logic ar, input logic br);
      #1;
      check({tag, ".a_ready"}, {15'd0, a_ready}, {15'd0, ar});
      check({tag, ".b_ready"}, {15'd0, b_ready}, {15'd0, br});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; a_data = '0; b_data = '0;
      a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
      #1;
      check_out("reset0", 16'h0000, 1'b0, 1'b0);
      step(); step();
      rst_n = 1'b1;

      // single channel a, one word per cycle
      a_valid = 1'b1; a_data = 16'h0001;
      check_rdy("single.rdy", 1'b1, 1'b0);
      step(); check_out("single1", 16'h0001, 1'b0, 1'b1);
      a_data = 16'h0002;
      step(); check_out("single2", 16'h0002, 1'b0, 1'b1);
      a_data = 16'h0003;
      step(); check_out("single3", 16'h0003, 1'b0, 1'b1);
      a_valid = 1'b0;

      // async reset mid-stream with a word held
      rst_n = 1'b0;
      #1;
      check_out("midreset", 16'h0000, 1'b0, 1'b0);
      a_data = 16'hAAAA; b_data = 16'hBBBB;
      a_valid = 1'b1; b_valid = 1'b1;
      step();
      rst_n = 1'b1;
      check_rdy("tie0.rdy", 1'b1, 1'b0);

      // contention alternates a, b, a, b
      step(); check_out("cont1", 16'hAAAA, 1'b0, 1'b1); check_rdy("cont1.rdy", 1'b0, 1'b1);
      step(); check_out("cont2", 16'hBBBB, 1'b1, 1'b1); check_rdy("cont2.rdy", 1'b1, 1'b0);
      step(); check_out("cont3", 16'hAAAA, 1'b0, 1'b1); check_rdy("cont3.rdy", 1'b0, 1'b1);
      step(); check_out("cont4", 16'hBBBB, 1'b1, 1'b1);

      // backpressure: fill with 0x1234 then stall 3 cycles
      b_valid = 1'b0; a_data = 16'h1234;
      step(); check_out("fill", 16'h1234, 1'b0, 1'b1);
      out_ready = 1'b0; a_data = 16'h5555; b_valid = 1'b1;
      check_rdy("stall0.rdy", 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_out("stall", 16'h1234, 1'b0, 1'b1);
         check_rdy("stall.rdy", 1'b0, 1'b0);
      end
      out_ready = 1'b1;
      check_rdy("release.rdy", 1'b0, 1'b1);
      step(); check_out("nobubble", 16'hBBBB, 1'b1, 1'b1);

      // drain to idle
      b_valid = 1'b0; a_data = 16'h00FF;
      step(); check_out("last_word", 16'h00FF, 1'b0, 1'b1);
      a_valid = 1'b0;
      step(); check_out("idle", 16'h00FF, 1'b0, 1'b0);
      step(); check_out("idle2", 16'h00FF, 1'b0, 1'b0);
      // last still a: a tie now goes to b
      a_valid = 1'b1; b_valid = 1'b1;
      check_rdy("after_idle.rdy", 1'b0, 1'b1);
      step(); check_out("after_idle", 16'hBBBB, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/h_mux_merge.md
# h_mux_merge

Two-to-one stream merger with round-robin arbitration and one registered output stage. It is the converging counterpart of the demultiplexer fabric: where the demux steers one source to one of two sinks, this block collects words from two producers (a, b) onto a single consumer. Every output word is tagged with the channel it came from, so a downstream demux can route replies back using that tag as its select.

## Interface
Parameters:
- WIDTH, 16, data word width (Hack word).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- a_data  input  WIDTH  channel a word.
- a_valid  input  1  channel a word present.
- a_ready  output  1  channel a word accepted this cycle.
- b_data  input  WIDTH  channel b word.
- b_valid  input  1  channel b word present.
- b_ready  output  1  channel b word accepted this cycle.
- out_data  output  WIDTH  registered merged word.
- out_sel  output  1  source tag of out_data: 0 = a, 1 = b.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  consumer accepts the word this cycle.

## Operation
- Handshake on every channel: a transfer occurs on a rising edge where valid and ready are both high.
  - A producer holds valid and data stable until the transfer.
  - valid never depends on ready. ready may depend on valid.
- load = !out_valid || out_ready. The output register can take a new word this cycle.
- Grant, computed combinationally from a_valid, b_valid and last:
  - Only a valid: grant a.
  - Only b valid: grant b.
  - Both valid: grant the channel that is not `last`.
  - Neither valid: no grant.
- a_ready = load && grant_a. b_ready = load && grant_b. At most one ready is high in any cycle.
- On a transfer:
  - out_data <= granted data.
  - out_sel <= granted index.
  - out_valid <= 1.
  - last <= granted index.
- If out_valid && out_ready and there is no grant: out_valid <= 0. out_data and out_sel keep their last values.
- If out_valid && !out_ready: all output registers hold, and both readys are 0.
- `last` updates only on a transfer. It does not change when only one channel is requesting and nothing is transferred.
- Arbiter state: a single bit `last`. Transitions: last -> a on an a transfer, last -> b on a b transfer, otherwise hold.

## Timing
- Reset values (async assert, applied immediately):
  - out_valid = 0, out_data = 0, out_sel = 0.
  - last = 1, so channel a wins the first tie.
  - a_ready and b_ready follow the reset state: high for whichever channel is valid and granted, since load = 1.
- Reset deassertion is used synchronously to clk. The first transfer can occur on the first rising edge after release.
- Latency: input transfer on edge N makes out_valid high after edge N.
- Throughput: one word per cycle when out_ready is held high.
- Fairness: with both channels continuously valid and out_ready high, the output alternates a, b, a, b… No channel waits more than one transfer.
- Back-to-back: a drain and a load in the same cycle (out_valid && out_ready && grant) replace the word with no bubble.
- Reset mid-operation: the held word is discarded, out_valid drops immediately, and the arbiter returns to a-priority. Producers see ready drop combinationally and keep their words.
- No combinational path from out_ready to out_data, out_sel or out_valid.

## Structure
- Shared header, included like the other base blocks:
  - SEL_A = 1'b0, SEL_B = 1'b1.
  - Default WIDTH = 16.
  - The downstream demux uses the same SEL encoding.
- Sub-module h_rr_arb2: two-requester round-robin arbiter.
  - Inputs: req[1:0], a `last` state bit, and an advance strobe.
  - Outputs: one-hot gnt[1:0].
  - Owns the `last` flop, with the same clk/rst_n.
- Top level: the load logic, the output register, and ready generation from gnt and load.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately. After release, with both channels valid, the first word out has out_sel=0.
- Single channel: a_valid=1 with a_data 0x0001, 0x0002, 0x0003 on consecutive cycles, out_ready=1 -> outputs 0x0001/0x0002/0x0003, all out_sel=0, one per cycle, 1-cycle latency.
- Contention: a holds 0xAAAA and b holds 0xBBBB, both valid for 4 transfers -> out sequence A, B, A, B with out_sel 0, 1, 0, 1. a_ready and b_ready are never high together.
- Backpressure: fill the output with 0x1234, hold out_ready=0 for 3 cycles while both channels are valid -> out_data stays 0x1234, a_ready=b_ready=0. out_ready=1 then transfers the next word in the same cycle, with no bubble.
- Drain to idle: the last word 0x00FF is taken with both valids low -> out_valid=0 on the next cycle, out_data still 0x00FF, `last` unchanged.
